// File: rtl/coverfloat_pkg.sv
// coverfloat_pkg: shared types and encodings for the coverfloat transaction path.
//   coverfloat_txn_t : one assembled test record (op, rm, formats, operands,
//                      96-bit expected result, expected flags)
//   cf_op_e / cf_round_e / cf_flag_e / cf_fmt_e : field encodings
//   CF_TXN_WORDS     : stream words per record frame
//   cf_fmt_legal()   : format byte membership test
package coverfloat_pkg;

  localparam int unsigned CF_TXN_WORDS = 19;

  typedef enum logic [31:0] {
    OP_ADD    = 32'd1,
    OP_SUB    = 32'd2,
    OP_MUL    = 32'd3,
    OP_DIV    = 32'd4,
    OP_FMADD  = 32'd5,
    OP_FMSUB  = 32'd6,
    OP_FNMADD = 32'd7,
    OP_FNMSUB = 32'd8,
    OP_SQRT   = 32'd9,
    OP_REM    = 32'd10,
    OP_CFI    = 32'd11,
    OP_CFF    = 32'd12,
    OP_CIF    = 32'd13
  } cf_op_e;

  typedef enum logic [31:0] {
    ROUND_NEAR_EVEN   = 32'd0,
    ROUND_MINMAG      = 32'd1,
    ROUND_MIN         = 32'd2,
    ROUND_MAX         = 32'd3,
    ROUND_NEAR_MAXMAG = 32'd4,
    ROUND_ODD         = 32'd5
  } cf_round_e;

  typedef enum logic [31:0] {
    FLAG_INEXACT   = 32'h01,
    FLAG_UNDERFLOW = 32'h02,
    FLAG_OVERFLOW  = 32'h04,
    FLAG_INFINITE  = 32'h08,
    FLAG_INVALID   = 32'h10
  } cf_flag_e;

  typedef enum logic [7:0] {
    FMT_HALF   = 8'h00,
    FMT_SINGLE = 8'h01,
    FMT_DOUBLE = 8'h02,
    FMT_QUAD   = 8'h03,
    FMT_BF16   = 8'h04,
    FMT_INT    = 8'h81,
    FMT_LONG   = 8'h82,
    FMT_UINT   = 8'hC1,
    FMT_ULONG  = 8'hC2
  } cf_fmt_e;

  typedef struct packed {
    logic [31:0]  op;
    logic [31:0]  rm;
    logic [7:0]   fmt_a;
    logic [7:0]   fmt_b;
    logic [7:0]   fmt_c;
    logic [7:0]   fmt_res;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    logic [95:0]  res;
    logic [31:0]  flags;
  } coverfloat_txn_t;

  function automatic logic cf_fmt_legal(input logic [7:0] fmt);
    case (fmt)
      FMT_HALF, FMT_SINGLE, FMT_DOUBLE, FMT_QUAD, FMT_BF16,
      FMT_INT, FMT_UINT, FMT_LONG, FMT_ULONG: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/coverfloat_txn_check.sv
// coverfloat_txn_check: combinational field validation of a candidate record.
//   op_i  [31:0] : op word
//   rm_i  [31:0] : rounding-mode word
//   fmt_i [31:0] : packed format bytes {fmt_a, fmt_b, fmt_c, fmt_res}
//   err_o [2:0]  : {bad format, bad rounding mode, bad op}
module coverfloat_txn_check
  import coverfloat_pkg::*;
(
  input  logic [31:0] op_i,
  input  logic [31:0] rm_i,
  input  logic [31:0] fmt_i,
  output logic [2:0]  err_o
);

  logic bad_op;
  logic bad_rm;
  logic bad_fmt;

  always_comb begin
    bad_op  = (op_i < OP_ADD) || (op_i > OP_CIF);
    bad_rm  = (rm_i > ROUND_ODD);
    // A quad result cannot fit the 96-bit result slot of a 19-word frame.
    bad_fmt = !cf_fmt_legal(fmt_i[31:24]) || !cf_fmt_legal(fmt_i[23:16]) ||
              !cf_fmt_legal(fmt_i[15:8])  || !cf_fmt_legal(fmt_i[7:0])   ||
              (fmt_i[7:0] == FMT_QUAD);
    err_o   = {bad_fmt, bad_rm, bad_op};
  end

endmodule

// File: rtl/coverfloat_txn_assembler.sv
// coverfloat_txn_assembler: builds one coverfloat_txn_t from a 32-bit word
// stream, validates frame length and field encodings, and holds one record
// for a valid/ready downstream.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream word handshake; in_data word, in_last ends frame
//   out_valid/out_ready   : downstream record handshake; out_txn record, out_err field errors
//   err_frame             : one-cycle pulse when a frame is dropped for bad length
//   txn_count             : records handed off (wraps)
//   err_count             : dropped frames (saturates)
module coverfloat_txn_assembler
  import coverfloat_pkg::*;
#(
  parameter int unsigned TXN_WORDS = CF_TXN_WORDS,
  parameter int unsigned ERRCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output coverfloat_txn_t     out_txn,
  output logic [2:0]          out_err,
  output logic                err_frame,
  output logic [31:0]         txn_count,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [4:0] LAST_IDX = 5'(TXN_WORDS - 1);

  typedef enum logic {ST_COLLECT, ST_DISCARD} state_e;

  state_e              state_q, state_d;
  logic [4:0]          idx_q, idx_d;
  logic [31:0]         shadow_q [TXN_WORDS-1];
  logic                shadow_we;
  coverfloat_txn_t     cand, txn_q, txn_d;
  logic [2:0]          cand_err, err_q, err_d;
  logic                valid_q, valid_d;
  logic                err_frame_q, err_frame_d;
  logic [31:0]         txn_cnt_q, txn_cnt_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                accept, handoff, load, drop;

  // Only the final word of a frame needs the output register, so only it stalls.
  assign in_ready = (state_q == ST_DISCARD) || (idx_q != LAST_IDX) || !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = valid_q && out_ready;

  // The final (flags) word is taken straight from the bus on load.
  always_comb begin
    cand         = '0;
    cand.op      = shadow_q[0];
    cand.rm      = shadow_q[1];
    cand.fmt_a   = shadow_q[2][31:24];
    cand.fmt_b   = shadow_q[2][23:16];
    cand.fmt_c   = shadow_q[2][15:8];
    cand.fmt_res = shadow_q[2][7:0];
    cand.a       = {shadow_q[3],  shadow_q[4],  shadow_q[5],  shadow_q[6]};
    cand.b       = {shadow_q[7],  shadow_q[8],  shadow_q[9],  shadow_q[10]};
    cand.c       = {shadow_q[11], shadow_q[12], shadow_q[13], shadow_q[14]};
    cand.res     = {shadow_q[15], shadow_q[16], shadow_q[17]};
    cand.flags   = in_data;
  end

  coverfloat_txn_check u_check (
    .op_i  (shadow_q[0]),
    .rm_i  (shadow_q[1]),
    .fmt_i (shadow_q[2]),
    .err_o (cand_err)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_we = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    if (accept) begin
      if (state_q == ST_DISCARD) begin
        if (in_last) state_d = ST_COLLECT;
      end else if (idx_q != LAST_IDX) begin
        shadow_we = 1'b1;
        if (in_last) begin
          idx_d = '0;
          drop  = 1'b1;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end else begin
        idx_d = '0;
        if (in_last) begin
          load = 1'b1;
        end else begin
          drop    = 1'b1;
          state_d = ST_DISCARD;
        end
      end
    end
  end

  always_comb begin
    valid_d     = load || (valid_q && !out_ready);
    txn_d       = load ? cand : txn_q;
    err_d       = load ? cand_err : err_q;
    err_frame_d = drop;
    txn_cnt_d   = handoff ? txn_cnt_q + 32'd1 : txn_cnt_q;
    err_cnt_d   = (drop && (err_cnt_q != '1)) ? err_cnt_q + ERRCNT_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      txn_q       <= '0;
      err_q       <= '0;
      err_frame_q <= 1'b0;
      txn_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      txn_q       <= txn_d;
      err_q       <= err_d;
      err_frame_q <= err_frame_d;
      txn_cnt_q   <= txn_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TXN_WORDS - 1; i++) shadow_q[i] <= '0;
    end else if (shadow_we) begin
      shadow_q[idx_q] <= in_data;
    end
  end

  assign out_valid = valid_q;
  assign out_txn   = txn_q;
  assign out_err   = err_q;
  assign err_frame = err_frame_q;
  assign txn_count = txn_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_coverfloat_txn_assembler.sv
module tb_coverfloat_txn_assembler;
  import coverfloat_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  coverfloat_txn_t out_txn;
  logic [2:0]      out_err;
  logic            err_frame;
  logic [31:0]     txn_count;
  logic [15:0]     err_count;

  coverfloat_txn_assembler #(.TXN_WORDS(19), .ERRCNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_txn   (out_txn),
    .out_err   (out_err),
    .err_frame (err_frame),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    coverfloat_txn_t txn;
    logic [2:0]      err;
  } exp_t;

  typedef struct {
    logic [31:0] op;
    logic [31:0] rm;
    logic [31:0] fmt;
    logic [2:0]  err;
  } vec_t;

  int              checks = 0;
  int              errors = 0;
  exp_t            expq[$];
  int              pushed = 0;
  int              drops = 0;
  int              pulses = 0;
  logic [31:0]     fw [0:31];
  logic [7:0]      legal_fmts [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h81, 8'hC1, 8'h82, 8'hC2};
  logic            smp_rdy;
  bit              held_v = 1'b0;
  coverfloat_txn_t held_txn;
  logic [2:0]      held_err;
  int              low_ticks = 0;
  bit              rand_ready = 1'b0;
  vec_t            vecs [11];

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected field errors, straight from the validity rules.
  function automatic logic [2:0] model_err(input logic [31:0] op, input logic [31:0] rm,
                                           input logic [31:0] fmt);
    bit bad_fmt = 0;
    for (int k = 0; k < 4; k++) begin
      bit found = 0;
      for (int j = 0; j < 9; j++) if (fmt[8*k +: 8] == legal_fmts[j]) found = 1;
      if (!found) bad_fmt = 1;
    end
    if (fmt[7:0] == 8'h03) bad_fmt = 1;
    return {bad_fmt, (rm > 32'd5), (op < 32'd1 || op > 32'd13)};
  endfunction

  function automatic coverfloat_txn_t frame_to_rec();
    coverfloat_txn_t r;
    r.op = fw[0];
    r.rm = fw[1];
    {r.fmt_a, r.fmt_b, r.fmt_c, r.fmt_res} = fw[2];
    r.a     = {fw[3], fw[4], fw[5], fw[6]};
    r.b     = {fw[7], fw[8], fw[9], fw[10]};
    r.c     = {fw[11], fw[12], fw[13], fw[14]};
    r.res   = {fw[15], fw[16], fw[17]};
    r.flags = fw[18];
    return r;
  endfunction

  task automatic build_frame(input logic [31:0] op, input logic [31:0] rm, input logic [31:0] fmt);
    fw[0] = op;
    fw[1] = rm;
    fw[2] = fmt;
    for (int i = 3; i < 32; i++) fw[i] = $urandom;
  endtask

  task automatic push_good(input logic [2:0] err);
    exp_t e;
    e.txn = frame_to_rec();
    e.err = err;
    expq.push_back(e);
    pushed++;
  endtask

  // One clock: observe at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    smp_rdy = in_ready;
    if (err_frame === 1'b1) pulses++;
    if (held_v && out_valid === 1'b1) begin
      chk("hold_txn", 640'(out_txn), 640'(held_txn));
      chk("hold_err", 640'(out_err), 640'(held_err));
    end
    held_v   = (out_valid === 1'b1) && !out_ready;
    held_txn = out_txn;
    held_err = out_err;
    if (out_valid === 1'b1 && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rec_unexpected: record %0h emitted, none expected", out_txn);
      end else begin
        e = expq.pop_front();
        chk("rec_txn", 640'(out_txn), 640'(e.txn));
        chk("rec_err", 640'(out_err), 640'(e.err));
      end
    end
    @(posedge clk);
    #1;
    if (low_ticks > 0) begin
      out_ready = 1'b0;
      low_ticks--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 2) != 0);
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic send_frame(input int len, input bit with_last, input bit bubbles,
                            output int st18, output int stoth);
    st18  = 0;
    stoth = 0;
    for (int i = 0; i < len; i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = fw[i];
      in_last  = with_last && (i == len - 1);
      for (int g = 0; g < 400; g++) begin
        tick();
        if (smp_rdy) break;
        if (i == 18) st18++;
        else stoth++;
        if (g == 399) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: word %0d in_ready=0, required 1 within 400 cycles", i);
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 400 && expq.size() > 0; g++) tick();
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d records outstanding, required 0", expq.size());
      expq.delete();
    end
    tick();
    tick();
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_txn_count"}, 640'(txn_count), 640'(pushed));
    chk({tag, "_err_count"}, 640'(err_count), 640'(drops));
    chk({tag, "_err_frame_pulses"}, 640'(pulses), 640'(drops));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st18, stoth, sa18, saoth, len;
    logic [31:0] op, rm, fmt;

    vecs[0]  = '{32'd1,          32'd0,     32'h01010101, 3'b000};
    vecs[1]  = '{32'd13,         32'd5,     32'h02020202, 3'b000};
    vecs[2]  = '{32'd0,          32'd0,     32'h01010101, 3'b001};
    vecs[3]  = '{32'd14,         32'd7,     32'h05010101, 3'b111};
    vecs[4]  = '{32'd3,          32'd6,     32'h81C182C2, 3'b010};
    vecs[5]  = '{32'd2,          32'd1,     32'h01010103, 3'b100};
    vecs[6]  = '{32'd4,          32'd2,     32'h03030300, 3'b000};
    vecs[7]  = '{32'd5,          32'd3,     32'h0101FF01, 3'b100};
    vecs[8]  = '{32'd7,          32'd4,     32'h04000201, 3'b000};
    vecs[9]  = '{32'h8000_0001,  32'd0,     32'h01010101, 3'b001};
    vecs[10] = '{32'd9,          32'h100,   32'h02020202, 3'b010};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", 640'(out_valid), 640'(0));
    chk("rst_out_txn",   640'(out_txn),   640'(0));
    chk("rst_out_err",   640'(out_err),   640'(0));
    chk("rst_err_frame", 640'(err_frame), 640'(0));
    chk("rst_txn_count", 640'(txn_count), 640'(0));
    chk("rst_err_count", 640'(err_count), 640'(0));
    chk("rst_in_ready",  640'(in_ready),  640'(1));

    // Single add frame
    for (int i = 0; i < 32; i++) fw[i] = '0;
    fw[0] = 32'd1; fw[2] = 32'h01010101; fw[6] = 32'h3F800000;
    fw[10] = 32'h40000000; fw[17] = 32'h40400000;
    push_good(3'b000);
    send_frame(19, 1'b1, 1'b0, st18, stoth);
    chk("add_latency_out_valid", 640'(out_valid), 640'(1));
    chk("add_a",   640'(out_txn.a),   640'(128'h3F800000));
    chk("add_res", 640'(out_txn.res), 640'(96'h40400000));
    chk("add_stalls", 640'(st18 + stoth), 640'(0));
    tick();
    chk("add_txn_count", 640'(txn_count), 640'(1));
    drain();
    check_counts("add");

    // Table of field encodings, back to back
    for (int v = 0; v < 11; v++) begin
      build_frame(vecs[v].op, vecs[v].rm, vecs[v].fmt);
      push_good(vecs[v].err);
      send_frame(19, 1'b1, 1'b0, st18, stoth);
    end
    drain();
    check_counts("table");

    // Backpressure: second frame's last word must stall while the first is held
    build_frame(32'd3, 32'd2, 32'h02020202);
    push_good(3'b000);
    low_ticks = 48;
    out_ready = 1'b0;
    send_frame(19, 1'b1, 1'b0, sa18, saoth);
    build_frame(32'd4, 32'd1, 32'h01010101);
    push_good(3'b000);
    send_frame(19, 1'b1, 1'b0, st18, stoth);
    chk("bp_first_stalls", 640'(sa18 + saoth), 640'(0));
    chk("bp_second_stall_w18", 640'(st18 >= 10), 640'(1));
    chk("bp_second_stall_other", 640'(stoth), 640'(0));
    drain();
    check_counts("bp");

    // Short frame then good frame
    build_frame(32'd1, 32'd0, 32'h01010101);
    drops++;
    send_frame(6, 1'b1, 1'b0, st18, stoth);
    chk("short_err_frame", 640'(err_frame), 640'(1));
    build_frame(32'd2, 32'd3, 32'h01020304);
    push_good(3'b000);
    send_frame(19, 1'b1, 1'b0, st18, stoth);
    drain();
    check_counts("short");

    // Long frame then good frame
    build_frame(32'd1, 32'd0, 32'h01010101);
    drops++;
    send_frame(21, 1'b1, 1'b0, st18, stoth);
    build_frame(32'd6, 32'd4, 32'hC2C18281);
    push_good(3'b000);
    send_frame(19, 1'b1, 1'b0, st18, stoth);
    drain();
    check_counts("long");

    // Bad fields still emitted
    build_frame(32'd14, 32'd7, 32'h05010101);
    push_good(3'b111);
    send_frame(19, 1'b1, 1'b0, st18, stoth);
    drain();
    check_counts("badfld");

    // Randomised frames, bubbles and downstream stalls
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 4) != 0) ? 19 : int'($urandom_range(1, 26));
      op  = $urandom_range(0, 15);
      rm  = $urandom_range(0, 7);
      for (int k = 0; k < 4; k++)
        fmt[8*k +: 8] = ($urandom_range(0, 3) != 0) ? legal_fmts[$urandom_range(0, 8)]
                                                     : 8'($urandom);
      build_frame(op, rm, fmt);
      if (len == 19) push_good(model_err(op, rm, fmt));
      else drops++;
      send_frame(len, 1'b1, 1'b1, st18, stoth);
    end
    rand_ready = 1'b0;
    drain();
    check_counts("rand");

    // Reset in the middle of a frame
    build_frame(32'd1, 32'd0, 32'h01010101);
    send_frame(9, 1'b0, 1'b0, st18, stoth);
    rst_n  = 1'b0;
    pushed = 0;
    drops  = 0;
    pulses = 0;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("mid_rst_out_valid", 640'(out_valid), 640'(0));
      chk("mid_rst_out_txn",   640'(out_txn),   640'(0));
      chk("mid_rst_out_err",   640'(out_err),   640'(0));
      chk("mid_rst_err_frame", 640'(err_frame), 640'(0));
      chk("mid_rst_txn_count", 640'(txn_count), 640'(0));
      chk("mid_rst_err_count", 640'(err_count), 640'(0));
    end
    rst_n = 1'b1;
    build_frame(32'd8, 32'd5, 32'h00000000);
    push_good(3'b000);
    send_frame(19, 1'b1, 1'b0, st18, stoth);
    drain();
    chk("post_rst_txn_count", 640'(txn_count), 640'(1));
    check_counts("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
